axi_lite_ram_ctrl: RTL and testbench

AXI_LITE_RAM_CTRL -- requirements
Module: axi_lite_ram_ctrl

---
 rtl/axi_lite_ram_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_ram_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ram_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_ram_ctrl
//
// AXI4-Lite slave that fronts a word-addressed on-chip RAM of SIZE words,
// each DWIDTH bits wide. Writes support per-byte strobes. Reads have a fixed
// two-cycle latency through a registered RAM output. The write and read
// channels run independent state machines and may be busy at the same time.
// Each channel holds at most one outstanding transaction.
//
// Addressing: the word index comes from addr[OFS+IDXW-1:OFS], and the
// byte-offset bits are ignored. An address with any bit set above the index
// field is out of range. Such an access gets SLVERR and never touches the
// RAM. An out-of-range read returns zero data.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset (RAM contents are kept)
//   awaddr/awvalid/awready                  write address channel
//   wdata/wstrb/wvalid/wready               write data channel
//   bresp/bvalid/bready                     write response channel
//   araddr/arvalid/arready                  read address channel
//   rdata/rresp/rvalid/rready               read data channel
// ---------------------------------------------------------------------------
module axi_lite_ram_ctrl #(
    parameter int DWIDTH     = 32,
    parameter int SIZE       = 2048,
    parameter int AWIDTH_BUS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [AWIDTH_BUS-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,

    input  logic [DWIDTH-1:0]       wdata,
    input  logic [DWIDTH/8-1:0]     wstrb,
    input  logic                    wvalid,
    output logic                    wready,

    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,

    input  logic [AWIDTH_BUS-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,

    output logic [DWIDTH-1:0]       rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BW   = DWIDTH / 8;
    localparam int OFS  = $clog2(BW);
    localparam int IDXW = $clog2(SIZE);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel states
    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_HAVE_A = 2'd1;
    localparam logic [1:0] W_HAVE_D = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;

    // Read channel states
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    // An address is valid only when every bit above the word-index field is zero.
    function automatic logic addr_in_range(input logic [AWIDTH_BUS-1:0] a);
        return (a >> (OFS + IDXW)) == '0;
    endfunction

    // Truncating shift: keeps only the word-index field.
    function automatic logic [IDXW-1:0] addr_index(input logic [AWIDTH_BUS-1:0] a);
        return IDXW'(a >> OFS);
    endfunction

    // RAM storage. It has no reset, so contents survive rst_n.
    logic [DWIDTH-1:0] mem [SIZE];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]        w_state_q, w_state_d;
    logic [IDXW-1:0]   aw_idx_q, aw_idx_d;
    logic              aw_ok_q, aw_ok_d;
    logic [DWIDTH-1:0] w_data_q, w_data_d;
    logic [BW-1:0]     w_strb_q, w_strb_d;
    logic [1:0]        bresp_q, bresp_d;

    logic              aw_hs;
    logic              w_hs;
    logic              commit;
    logic [IDXW-1:0]   commit_idx;
    logic              commit_ok;
    logic [DWIDTH-1:0] commit_data;
    logic [BW-1:0]     commit_strb;
    logic              mem_we;

    // The ready signals depend only on state (and reset), never on the
    // valid inputs. This keeps the handshake free of combinational loops.
    assign awready = rst_n && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_D));
    assign wready  = rst_n && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_A));
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // The write FSM collects address and data in either order. The commit
    // happens on the edge of the second handshake. The half that arrives
    // on that edge comes straight from the bus. The other half comes from
    // the holding registers.
    always_comb begin
        w_state_d   = w_state_q;
        aw_idx_d    = aw_idx_q;
        aw_ok_d     = aw_ok_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bresp_d     = bresp_q;
        commit      = 1'b0;
        commit_idx  = aw_idx_q;
        commit_ok   = aw_ok_q;
        commit_data = w_data_q;
        commit_strb = w_strb_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    commit_idx  = addr_index(awaddr);
                    commit_ok   = addr_in_range(awaddr);
                    commit_data = wdata;
                    commit_strb = wstrb;
                    w_state_d   = W_RESP;
                end else if (aw_hs) begin
                    aw_idx_d  = addr_index(awaddr);
                    aw_ok_d   = addr_in_range(awaddr);
                    w_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    w_data_d  = wdata;
                    w_strb_d  = wstrb;
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    commit      = 1'b1;
                    commit_data = wdata;
                    commit_strb = wstrb;
                    w_state_d   = W_RESP;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    commit_idx = addr_index(awaddr);
                    commit_ok  = addr_in_range(awaddr);
                    w_state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase

        // The response code is chosen at commit and stays fixed while it waits for bready.
        if (commit) begin
            bresp_d = commit_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign mem_we = commit && commit_ok;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [1:0]        r_state_q, r_state_d;
    logic              ar_ok_q, ar_ok_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DWIDTH-1:0] ram_rd_q;
    logic              ar_hs;

    assign arready = rst_n && (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign ar_hs   = arvalid && arready;

    // The RAM is read on the AR handshake edge. R_WAIT then moves that word
    // into the output register, which gives the fixed two-cycle latency.
    // Out-of-range reads are forced to zero when the output register loads.
    always_comb begin
        r_state_d = r_state_q;
        ar_ok_d   = ar_ok_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_ok_d   = addr_in_range(araddr);
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                rdata_d   = ar_ok_q ? ram_rd_q : '0;
                rresp_d   = ar_ok_q ? RESP_OKAY : RESP_SLVERR;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM array
    // ------------------------------------------------------------------
    // Byte-enable write and a registered read share one edge. Non-blocking
    // semantics make a read on the same edge as a write see the old word
    // (read-first).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BW; b++) begin
                if (commit_strb[b]) begin
                    mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
                end
            end
        end
        if (ar_hs) begin
            ram_rd_q <= mem[addr_index(araddr)];
        end
    end

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            aw_idx_q  <= '0;
            aw_ok_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            ar_ok_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_idx_q  <= aw_idx_d;
            aw_ok_q   <= aw_ok_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            ar_ok_q   <= ar_ok_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_ram_ctrl
//
// Directed bench for axi_lite_ram_ctrl with default parameters (32-bit data,
// 2048 words). The stimulus tasks push each expected B and R response into a
// queue when the transaction is issued. A separate monitor pops the next
// entry and compares it whenever a B or R handshake is about to happen.
// ---------------------------------------------------------------------------
module tb_axi_lite_ram_ctrl;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total;
    int bad;

    logic [1:0]  exp_bresp[$];
    logic [31:0] exp_rdata[$];
    logic [1:0]  exp_rresp[$];

    logic [1:0]  mon_bresp;
    logic [31:0] mon_rdata;
    logic [1:0]  mon_rresp;

    axi_lite_ram_ctrl #(
        .DWIDTH(32),
        .SIZE(2048),
        .AWIDTH_BUS(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .awaddr(awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp),
        .bvalid(bvalid),
        .bready(bready),
        .araddr(araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rresp(rresp),
        .rvalid(rvalid),
        .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some wait is never bounded
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out waiting for ready, got 0 expected 1", name);
    endtask

    // which: 0=awready, 1=wready, 2=arready, 3=awready&wready, 4=awready&arready
    task automatic wait_ready(input int which);
        logic ok;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            case (which)
                0: ok = awready;
                1: ok = wready;
                2: ok = arready;
                3: ok = awready && wready;
                default: ok = awready && arready;
            endcase
            if (ok) return;
        end
        report_timeout($sformatf("ready_wait_%0d", which));
    endtask

    // mode 0: AW and W in the same cycle; 1: AW first; 2: W first, AW three cycles later
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input logic [1:0] exp_resp);
        exp_bresp.push_back(exp_resp);
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        if (mode == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
            wait_ready(3);
            @(posedge clk); #1;
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end else if (mode == 1) begin
            awvalid = 1'b1;
            wait_ready(0);
            @(posedge clk); #1;
            awvalid = 1'b0;
            @(negedge clk);
            check("have_a_awready", awready, 1'b0);
            check("have_a_wready", wready, 1'b1);
            @(posedge clk); #1;
            wvalid = 1'b1;
            wait_ready(1);
            @(posedge clk); #1;
            wvalid = 1'b0;
        end else begin
            wvalid = 1'b1;
            wait_ready(1);
            @(posedge clk); #1;
            wvalid = 1'b0;
            @(negedge clk);
            check("have_d_awready", awready, 1'b1);
            check("have_d_wready", wready, 1'b0);
            repeat (2) @(posedge clk);
            #1;
            awvalid = 1'b1;
            wait_ready(0);
            @(posedge clk); #1;
            awvalid = 1'b0;
        end
        @(negedge clk);
        check("bvalid_after_commit", bvalid, 1'b1);
        if (bready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        exp_rdata.push_back(exp_data);
        exp_rresp.push_back(exp_resp);
        araddr  = addr;
        arvalid = 1'b1;
        wait_ready(2);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_edge_n", rvalid, 1'b0);
        @(negedge clk);
        check("rvalid_edge_n1", rvalid, 1'b1);
        if (rready) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: compares on the cycle before each B/R handshake edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bvalid && bready) begin
                if (exp_bresp.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL b_unexpected: got bresp 0x%0h, expected no response", bresp);
                end else begin
                    mon_bresp = exp_bresp.pop_front();
                    check("b_resp", bresp, mon_bresp);
                end
            end
            if (rvalid && rready) begin
                if (exp_rdata.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL r_unexpected: got rdata 0x%0h, expected no response", rdata);
                end else begin
                    mon_rdata = exp_rdata.pop_front();
                    mon_rresp = exp_rresp.pop_front();
                    check("r_data", rdata, mon_rdata);
                    check("r_resp", rresp, mon_rresp);
                end
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_awready", awready, 1'b1);
        check("idle_arready", arready, 1'b1);
        @(posedge clk); #1;

        // Simultaneous AW+W write, then read back
        $display("[TB] basic write/read");
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, OKAY);
        axi_read(32'h10, 32'hDEADBEEF, OKAY);

        // W first, partial strobe merges into the existing word
        $display("[TB] data-first partial write");
        axi_write(32'h10, 32'h0000AAAA, 4'h3, 2, OKAY);
        axi_read(32'h10, 32'hDEADAAAA, OKAY);

        // Backpressure on B and R: responses must hold steady
        $display("[TB] backpressure");
        @(posedge clk); #1;
        bready = 1'b0;
        rready = 1'b0;
        axi_write(32'h08, 32'h12345678, 4'hF, 0, OKAY);
        @(posedge clk); #1;
        axi_read(32'h08, 32'h12345678, OKAY);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", bvalid, 1'b1);
            check("hold_bresp", bresp, OKAY);
            check("hold_rvalid", rvalid, 1'b1);
            check("hold_rdata", rdata, 32'h12345678);
            check("hold_arready", arready, 1'b0);
            check("hold_awready", awready, 1'b0);
            check("hold_wready", wready, 1'b0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("released_bvalid", bvalid, 1'b0);
        check("released_rvalid", rvalid, 1'b0);
        @(posedge clk); #1;

        // Out-of-range accesses, including one that would alias word 4
        $display("[TB] out of range");
        axi_write(32'h0, 32'h0BADF00D, 4'hF, 1, OKAY);
        axi_write(32'h2000, 32'hFFFFFFFF, 4'hF, 0, SLVERR);
        axi_read(32'h2000, 32'h0, SLVERR);
        axi_read(32'h0, 32'h0BADF00D, OKAY);
        axi_write(32'h8000_0010, 32'h77777777, 4'hF, 0, SLVERR);
        axi_read(32'h8000_0010, 32'h0, SLVERR);
        axi_read(32'h10, 32'hDEADAAAA, OKAY);

        // Read-first collision on word 5
        $display("[TB] collision");
        axi_write(32'h14, 32'h55555555, 4'hF, 0, OKAY);
        exp_bresp.push_back(OKAY);
        exp_rdata.push_back(32'h55555555);
        exp_rresp.push_back(OKAY);
        awaddr  = 32'h14;
        awvalid = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata   = 32'hA5A5A5A5;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        araddr  = 32'h14;
        arvalid = 1'b1;
        @(negedge clk);
        check("coll_wready", wready, 1'b1);
        check("coll_arready", arready, 1'b1);
        @(posedge clk); #1;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        @(negedge clk);
        check("coll_bvalid", bvalid, 1'b1);
        check("coll_rvalid_n", rvalid, 1'b0);
        @(negedge clk);
        check("coll_rvalid_n1", rvalid, 1'b1);
        @(posedge clk); #1;
        axi_read(32'h14, 32'hA5A5A5A5, OKAY);

        // Reset in the middle of W_HAVE_A and R_WAIT
        $display("[TB] mid-transaction reset");
        axi_write(32'h18, 32'h11112222, 4'hF, 0, OKAY);
        awaddr  = 32'h18;
        awvalid = 1'b1;
        araddr  = 32'h10;
        arvalid = 1'b1;
        wait_ready(4);
        @(posedge clk); #1;
        awvalid = 1'b0;
        arvalid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_bvalid", bvalid, 1'b0);
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_awready", awready, 1'b0);
        check("midrst_wready", wready, 1'b0);
        check("midrst_arready", arready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        axi_read(32'h18, 32'h11112222, OKAY);
        axi_write(32'h1C, 32'hCAFEF00D, 4'hF, 1, OKAY);
        axi_read(32'h1C, 32'hCAFEF00D, OKAY);

        repeat (3) @(posedge clk);
        #1;
        check("b_queue_drained", exp_bresp.size(), 0);
        check("r_queue_drained", exp_rdata.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
